// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings, controller states and alignment mask shared by the byte RAM controller
package mem_pkg;
  typedef enum logic [1:0] {
    BYTE       = 2'd0,
    HALFWORD   = 2'd1,
    WORD       = 2'd2,
    DOUBLEWORD = 2'd3
  } len_e;
  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    XFER,
    ACK,
    DW_GAP
  } state_e;
  function automatic logic [2:0] align_mask(input len_e len);
    return len == BYTE ? 3'b000 : len == HALFWORD ? 3'b001 : len == WORD ? 3'b011 : 3'b111;
  endfunction
endpackage

// File: rtl/ram_array.sv
// ram_array: byte-wide storage seen as four big-endian byte lanes starting at addr, wrapping at the top
module ram_array #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [7:0] mem [2**AW];
  // write enabled lanes; lane 0 is the byte at addr and carries the MS byte
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[3-i]) mem[addr + AW'(i)] <= wdata[31-8*i -: 8];
  // gather four consecutive bytes, MS byte from the lowest address
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) rdata[31-8*i -: 8] = mem[addr + AW'(i)];
  end
endmodule

// File: rtl/byte_ram_ctrl.sv
// byte_ram_ctrl: handshaked big-endian byte/half/word/doubleword access controller with wait states and alignment check
module byte_ram_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 1,
  parameter int CHECK_ALIGN = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  read_write,
  input  logic                  sig,
  input  logic [1:0]            data_length,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  moc,
  output logic                  err
);
  localparam state_e GO = (WAIT_STATES > 0) ? WAIT : XFER;
  localparam logic [3:0] CNT_LD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  state_e state_q, state_d;
  len_e len_q, len_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] din_q, din_d, dout_q, dout_d;
  logic rw_q, rw_d, sig_q, sig_d, moc_q, moc_d, err_q, err_d;
  logic bad_q, bad_d, beat2_q, beat2_d, armed_q, armed_d;
  logic [31:0] rdata, ext, wdata;
  logic [3:0] be;
  logic misal;
  assign misal = CHECK_ALIGN != 0 && (address[2:0] & align_mask(len_e'(data_length))) != 3'b000;
  assign ext = len_q == BYTE ? {{24{sig_q & rdata[31]}}, rdata[31:24]} :
               len_q == HALFWORD ? {{16{sig_q & rdata[31]}}, rdata[31:16]} : rdata;
  assign wdata = len_q == BYTE ? {din_q[7:0], 24'b0} : len_q == HALFWORD ? {din_q[15:0], 16'b0} : din_q;
  assign be = len_q == BYTE ? 4'b1000 : len_q == HALFWORD ? 4'b1100 : 4'b1111;
  assign data_out = dout_q;
  assign moc = moc_q;
  assign err = err_q;
  ram_array #(.AW(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (state_q == XFER && !rw_q),
    .be    (be),
    .addr  (addr_q),
    .wdata (wdata),
    .rdata (rdata)
  );
  // next state, request capture and registered handshake outputs; moc/err trail the ACK state by one cycle
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    rw_d    = rw_q;
    sig_d   = sig_q;
    bad_d   = bad_q;
    beat2_d = beat2_q;
    armed_d = armed_q;
    moc_d   = state_q == ACK;
    err_d   = state_q == ACK && bad_q;
    case (state_q)
      IDLE: begin
        armed_d = armed_q | ~enable;
        if (enable && armed_q) begin
          armed_d = 1'b0;
          rw_d    = read_write;
          sig_d   = sig;
          len_d   = len_e'(data_length);
          addr_d  = address;
          din_d   = data_in;
          beat2_d = 1'b0;
          bad_d   = misal;
          cnt_d   = CNT_LD;
          state_d = misal ? ACK : GO;
        end
      end
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? XFER : WAIT;
      end
      XFER: begin
        dout_d  = rw_q ? ext : dout_q;
        state_d = ACK;
      end
      ACK: if (!enable) state_d = (len_q == DOUBLEWORD && !beat2_q && !bad_q) ? DW_GAP : IDLE;
      DW_GAP: begin
        if (enable) begin
          din_d   = data_in;
          addr_d  = addr_q + ADDR_WIDTH'(4);
          beat2_d = 1'b1;
          cnt_d   = CNT_LD;
          state_d = GO;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; memory contents survive reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      len_q   <= BYTE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      rw_q    <= 1'b0;
      sig_q   <= 1'b0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
      beat2_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      rw_q    <= rw_d;
      sig_q   <= sig_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
      beat2_q <= beat2_d;
      armed_q <= armed_d;
    end
endmodule

// File: tb/tb_byte_ram_ctrl.sv
// tb_byte_ram_ctrl: directed handshakes with a scoreboard checked on every moc rising edge
module tb_byte_ram_ctrl;
  import mem_pkg::*;
  localparam int WS = 1;
  typedef struct {
    logic [31:0] d;
    logic        e;
    logic        c;
    int          id;
  } exp_t;
  logic clk = 0, reset_n = 0, enable = 0, read_write = 0, sig = 0;
  logic [1:0] data_length = 0;
  logic [8:0] address = 0;
  logic [31:0] data_in = 0, data_out;
  logic moc, err, moc_prev = 0;
  exp_t sb[$];
  int checks = 0, errors = 0, tag = 0, last_lat = 0;
  logic [31:0] last_rd = 0;
  byte_ram_ctrl #(.ADDR_WIDTH(9), .WAIT_STATES(WS), .CHECK_ALIGN(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .read_write(read_write), .sig(sig),
    .data_length(data_length), .address(address), .data_in(data_in),
    .data_out(data_out), .moc(moc), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask
  // scoreboard monitor: pop on each moc rise, and err must be low once moc falls
  always @(negedge clk) begin
    if (moc === 1'b1 && moc_prev === 1'b0) begin
      if (sb.size() == 0) chk("unexpected_moc", 32'(moc), 32'd0);
      else begin
        exp_t x;
        x = sb.pop_front();
        chk($sformatf("sb%0d_err", x.id), 32'(err), 32'(x.e));
        if (x.c) chk($sformatf("sb%0d_data", x.id), data_out, x.d);
      end
    end
    if (moc === 1'b0 && moc_prev === 1'b1) chk("err_with_moc", 32'(err), 32'd0);
    moc_prev = moc;
  end
  task automatic push(input logic [31:0] d, input logic e, input logic c);
    sb.push_back('{d, e, c, tag});
    tag++;
  endtask
  task automatic raise(input logic rw, input logic sg, input logic [1:0] len, input logic [8:0] a, input logic [31:0] din);
    @(negedge clk);
    enable = 1; read_write = rw; sig = sg; data_length = len; address = a; data_in = din;
  endtask
  task automatic wait_moc(output int n);
    n = 0;
    while (moc !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (moc !== 1'b1) chk("moc_timeout", 32'(moc), 32'd1);
  endtask
  task automatic finish_hs();
    int n;
    wait_moc(last_lat);
    enable = 0;
    n = 0;
    while (moc !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (moc !== 1'b0) chk("moc_fall_timeout", 32'(moc), 32'd0);
    @(negedge clk);
  endtask
  task automatic xact(input logic rw, input logic sg, input logic [1:0] len, input logic [8:0] a,
                      input logic [31:0] din, input logic [31:0] ed, input logic ee, input logic ec);
    push(ed, ee, ec);
    raise(rw, sg, len, a, din);
    finish_hs();
  endtask
  task automatic wr(input logic [1:0] len, input logic [8:0] a, input logic [31:0] din);
    xact(0, 0, len, a, din, 0, 0, 0);
  endtask
  task automatic rd(input logic [1:0] len, input logic sg, input logic [8:0] a, input logic [31:0] exp);
    xact(1, sg, len, a, 32'h0, exp, 0, 1);
    last_rd = exp;
  endtask
  task automatic bad(input logic rw, input logic [1:0] len, input logic [8:0] a);
    xact(rw, 0, len, a, 32'h12345678, last_rd, 1, 1);
  endtask
  initial begin
    int n, hi;
    #22;
    chk("rst_moc", 32'(moc), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_data", data_out, 32'd0);
    @(negedge clk);
    reset_n = 1;
    wr(WORD, 9'h010, 32'hDEADBEEF);
    chk("lat_wr", last_lat, WS + 3);
    rd(WORD, 0, 9'h010, 32'hDEADBEEF);
    chk("lat_rd", last_lat, WS + 3);
    rd(BYTE, 0, 9'h011, 32'h000000AD);
    rd(BYTE, 1, 9'h010, 32'hFFFFFFDE);
    rd(BYTE, 0, 9'h010, 32'h000000DE);
    rd(HALFWORD, 1, 9'h012, 32'hFFFFBEEF);
    rd(HALFWORD, 0, 9'h012, 32'h0000BEEF);
    rd(WORD, 1, 9'h010, 32'hDEADBEEF);
    wr(WORD, 9'h018, 32'h00000000);
    wr(BYTE, 9'h019, 32'hAABBCCC3);
    wr(HALFWORD, 9'h01A, 32'h99991234);
    rd(WORD, 0, 9'h018, 32'h00C31234);
    wr(DOUBLEWORD, 9'h020, 32'h11223344);
    xact(1, 1, BYTE, 9'h1FF, 32'h55667788, 0, 0, 0);
    rd(WORD, 0, 9'h020, 32'h11223344);
    rd(WORD, 0, 9'h024, 32'h55667788);
    rd(DOUBLEWORD, 0, 9'h020, 32'h11223344);
    xact(0, 1, BYTE, 9'h155, 32'hFFFFFFFF, 32'h55667788, 0, 1);
    last_rd = 32'h55667788;
    rd(WORD, 0, 9'h024, 32'h55667788);
    wr(WORD, 9'h014, 32'hA5A5A5A5);
    rd(WORD, 0, 9'h018, 32'h00C31234);
    bad(0, WORD, 9'h013);
    chk("lat_err", last_lat, 2);
    bad(1, HALFWORD, 9'h011);
    bad(0, DOUBLEWORD, 9'h024);
    rd(WORD, 0, 9'h010, 32'hDEADBEEF);
    rd(WORD, 0, 9'h014, 32'hA5A5A5A5);
    rd(WORD, 0, 9'h024, 32'h55667788);
    wr(WORD, 9'h030, 32'h01020304);
    rd(WORD, 0, 9'h010, 32'hDEADBEEF);
    raise(0, 0, WORD, 9'h030, 32'hCAFEBABE);
    @(negedge clk);
    reset_n = 0;
    #1;
    chk("rst_mid_moc", 32'(moc), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    chk("rst_mid_data", data_out, 32'd0);
    enable = 0;
    @(negedge clk);
    reset_n = 1;
    last_rd = 0;
    rd(WORD, 0, 9'h030, 32'h01020304);
    push(32'hDEADBEEF, 0, 1);
    raise(1, 0, WORD, 9'h010, 32'h0);
    wait_moc(n);
    enable = 0;
    @(negedge clk);
    enable = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("hold_moc%0d", i), 32'(moc), 32'd0);
      chk($sformatf("hold_data%0d", i), data_out, 32'hDEADBEEF);
    end
    enable = 0;
    repeat (2) @(negedge clk);
    push(32'h11223344, 0, 1);
    raise(1, 0, WORD, 9'h020, 32'h0);
    @(negedge clk);
    enable = 0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (moc === 1'b1) hi++;
    end
    chk("drop_moc_cycles", hi, 1);
    chk("drop_data", data_out, 32'h11223344);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/byte_ram_ctrl.md
Name: byte_ram_ctrl

Overview:
- Clocked, parametrised successor of the datapath byte-addressable RAM.
- Sits between the control unit and the memory array on the data path. Serves byte, halfword, word and doubleword accesses, big-endian.
- Adds configurable wait states, a 4-phase enable/moc handshake, sign extension driven by `sig`, an alignment error flag, and a true two-beat doubleword transfer.

Parameters:
- ADDR_WIDTH, 9, byte-address width; array depth = 2**ADDR_WIDTH bytes.
- WAIT_STATES, 1, extra cycles between request capture and moc assertion; range 0..15.
- CHECK_ALIGN, 1, when 1, misaligned accesses raise err and do not touch memory.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  request strobe, level held by the master until moc is seen.
- read_write  in  1  1 = read, 0 = write.
- sig  in  1  1 = sign-extend byte/halfword reads, 0 = zero-extend.
- data_length  in  2  0 BYTE, 1 HALFWORD, 2 WORD, 3 DOUBLEWORD.
- address  in  ADDR_WIDTH  byte address, sampled at request capture.
- data_in  in  32  write data; MS byte at the lowest address.
- data_out  out  32  read data, registered.
- moc  out  1  memory operation complete.
- err  out  1  access rejected (misaligned); valid while moc is high.

Behaviour:
- Reset: one clock domain (`clk`); reset is asynchronous and active-low (`reset_n`). Asserting it forces the FSM to IDLE and clears data_out=0, moc=0, err=0 and the wait counter. Memory contents are not reset. Reset mid-transfer abandons it; any bytes already written stay written.
- States: IDLE, WAIT, XFER, ACK, DW_GAP.
- IDLE:
  - On enable=1, capture read_write, sig, data_length, address and data_in.
  - Go to WAIT if WAIT_STATES>0, else to XFER.
- WAIT: counts WAIT_STATES cycles, then goes to XFER.
- XFER: single cycle.
  - Write: store 1/2/4 bytes from data_in big-endian (BYTE uses data_in[7:0]; HALFWORD uses [15:0]).
  - Read: load data_out.
    - BYTE/HALFWORD are sign- or zero-extended per sig.
    - WORD and DOUBLEWORD ignore sig.
  - Next state: ACK.
- ACK:
  - moc=1 (registered).
  - Held until enable is sampled 0; then moc=0 next cycle.
  - Next state: DW_GAP if this was beat 1 of a DOUBLEWORD, else IDLE.
- Latency: enable sampled high at edge N gives moc=1 after edge N+2+WAIT_STATES.
- DOUBLEWORD, two beats:
  - Beat 1 covers address..address+3.
  - DW_GAP waits for the next enable=1, captures new data_in, and re-enters WAIT/XFER for address+4..address+7.
  - On beat 2 only data_in is sampled; all other request inputs are ignored.
  - Reads return word 1 in beat 1 and word 2 in beat 2.
- Alignment (CHECK_ALIGN=1):
  - HALFWORD needs address[0]=0; WORD needs address[1:0]=0; DOUBLEWORD needs address[2:0]=0.
  - On violation: skip WAIT, go straight to ACK with err=1 and moc=1. No write occurs; data_out keeps its previous value. A DOUBLEWORD gets no second beat.
  - err clears when moc clears.
- CHECK_ALIGN=0: no check; byte addresses wrap modulo 2**ADDR_WIDTH (e.g. WORD at the top address wraps to 0).
- Boundaries:
  - enable dropped during WAIT/XFER: the transfer still completes. moc rises for one cycle, then falls because enable is already low.
  - enable held high after moc falls: no new request is captured until enable has been seen 0 in IDLE (edge-qualified).
- data_out changes only in XFER of a read.

Decomposition:
- Shared package `mem_pkg`:
  - data_length encodings: BYTE, HALFWORD, WORD, DOUBLEWORD.
  - FSM state enum.
  - Alignment-mask function.
- Sub-module `ram_array`: byte-wide array with 4 byte lanes, big-endian lane mapping, and address wrap; no reset.
- `byte_ram_ctrl` holds the FSM, counter, extension and error logic.

Test Plan:
- WORD write 0xDEADBEEF @0x010 with WAIT_STATES=1, then WORD read @0x010 -> moc rises 3 cycles after enable; data_out=0xDEADBEEF. BYTE read @0x011 -> 0x000000AD.
- BYTE read @0x010 with sig=1 -> 0xFFFFFFDE; with sig=0 -> 0x000000DE. HALFWORD read @0x012 with sig=1 -> 0xFFFFBEEF.
- DOUBLEWORD write 0x11223344 then 0x55667788 @0x020 -> two complete handshakes. WORD reads give @0x020=0x11223344 and @0x024=0x55667788.
- WORD write @0x013 with CHECK_ALIGN=1 -> moc=1 and err=1 one cycle after capture; memory @0x010..0x017 unchanged. err falls with moc.
- Assert reset_n=0 during WAIT of a write -> moc=0, err=0 and data_out=0 immediately; the write does not occur. The next request is served normally.
- Hold enable high across two cycles after moc falls -> no second transfer; data_out is stable and moc stays 0.
